serial_subtractor16: RTL and testbench
======================================

Name: serial_subtractor16

Overview:
Bit-serial two's-complement subtractor computing diff = a - b over WIDTH clock cycles, one bit per cycle, LSB first.
- Small-area counterpart to the combinational ripple adder.
- Used by the ALU sequencer when area matters more than latency.
- Valid/ready handshake on both the operand side and the result side.
- Result includes unsigned borrow, signed overflow and zero flags.

Parameters:
- WIDTH, 16, operand and result width in bits (must be >= 2).
- CNT_W, 5, bit-counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operands a and b are valid.
- in_ready  output  1  block can accept operands (IDLE only).
- a  input  WIDTH  minuend.
- b  input  WIDTH  subtrahend.
- out_valid  output  1  result and flags are valid (DONE only).
- out_ready  input  1  consumer accepts the result.
- diff  output  WIDTH  a - b, modulo 2**WIDTH.
- borrow  output  1  1 when a < b, unsigned.
- overflow  output  1  signed overflow of a - b.
- zero  output  1  diff == 0.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, in_ready=1, out_valid=0.
  - diff=0, borrow=0, overflow=0, zero=0.
  - Internal a/b shift registers, carry and counter cleared.
  - Takes effect immediately, mid-operation included; any in-flight result is discarded, no out_valid pulse.
- States: IDLE -> RUN -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1: latch a into sh_a and ~b into sh_b, set carry=1, count=0, go to RUN.
  - in_valid=0 holds IDLE.
- RUN (in_ready=0, out_valid=0), on each edge:
  - s = sh_a[0] ^ sh_b[0] ^ carry.
  - carry <= majority(sh_a[0], sh_b[0], carry).
  - diff shifts right with s entering the MSB.
  - sh_a and sh_b shift right; count++.
  - On the edge where count == WIDTH-1: go to DONE.
  - Flags are registered on that same edge from the final s, the final carry-out and the latched MSBs.
- Latency: operands accepted on edge k; out_valid=1 after edge k+WIDTH.
- DONE:
  - out_valid=1; diff and flags held stable.
  - Edge with out_ready=1 -> IDLE.
  - out_ready=0 holds indefinitely (backpressure); in_valid is ignored and in_ready=0.
- Flags:
  - borrow = ~carry_out.
  - overflow = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the original operand MSBs (kept in a 2-bit register).
  - zero = (diff == 0). Computed serially: the flag is ANDed with ~s each bit, so no WIDTH-wide compare is needed.
- No accept in the same cycle as result hand-off; minimum spacing between operations is WIDTH+2 cycles.
- Wrap-around is natural modulo 2**WIDTH; no saturation.
- in_valid and operand changes during RUN/DONE have no effect.

Optional Feature:
- SERIAL_SUB_ADD_MODE_EN defined:
  - Adds input port `add_mode` (1 bit), sampled only at acceptance.
  - add_mode=1 computes a + b: sh_b <= b, carry <= 0. borrow then reports carry-out (unsigned overflow).
  - overflow = (a[MSB] == b[MSB]) & (diff[MSB] != a[MSB]).
  - add_mode=0 behaves exactly as a subtract.
- Undefined: no add_mode port; subtract only.

Decomposition:
- Shared package `alu_serial_pkg`:
  - state enum {IDLE, RUN, DONE}.
  - Localparam DEFAULT_WIDTH=16.
  - Function for minimum CNT_W.
- One natural sub-module: `serial_bit_cell`. It holds the carry flop, computes s and next carry, and has a load input with a carry preset value. The top instantiates it once; the top holds the FSM, shifters, counter and flags.

Test Plan:
- a=0x0005, b=0x0003 -> after 16 cycles: out_valid=1, diff=0x0002, borrow=0, overflow=0, zero=0.
- a=0x0003, b=0x0005 -> diff=0xFFFE, borrow=1, overflow=0, zero=0.
- a=0x8000, b=0x0001 -> diff=0x7FFF, overflow=1, borrow=0. a=0x7FFF, b=0xFFFF -> diff=0x8000, overflow=1, borrow=1.
- a=b=0x1234 -> diff=0x0000, zero=1. Hold out_ready=0 for 10 cycles: outputs stable, in_ready=0, a new in_valid is ignored. Then out_ready=1 -> IDLE next edge.
- Accept a=0x00FF, b=0x0001, then pulse rst_n low at RUN cycle 7 -> immediately out_valid=0, in_ready=1, diff=0. A new op a=0x0010, b=0x0010 yields diff=0, zero=1.
- With SERIAL_SUB_ADD_MODE_EN, add_mode=1:
  - a=0xFFFF, b=0x0001 -> diff=0x0000, borrow(carry)=1, zero=1.
  - a=0x7FFF, b=0x0001 -> diff=0x8000, overflow=1.

Source files
------------

// File: rtl/alu_serial_pkg.sv
// ============================================================================
// Module : alu_serial_pkg
// Brief  : Shared types and helpers for the bit-serial ALU datapath blocks.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_serial_pkg;

    localparam int DEFAULT_WIDTH = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Smallest counter width whose range strictly exceeds the operand width.
    function automatic int min_cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage : alu_serial_pkg

`default_nettype wire

// File: rtl/serial_bit_cell.sv
// ============================================================================
// Module : serial_bit_cell
// Brief  : One-bit full-adder slice with a carry flop, preset on load.
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_bit_cell (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic carry_preset,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic s,
    output logic carry_next
);

    logic carry_q;
    logic carry_d;

    assign s          = a_bit ^ b_bit ^ carry_q;
    assign carry_next = (a_bit & b_bit) | (a_bit & carry_q) | (b_bit & carry_q);

    always_comb begin
        carry_d = carry_q;
        if (load) begin
            carry_d = carry_preset;
        end else if (en) begin
            carry_d = carry_next;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

endmodule : serial_bit_cell

`default_nettype wire

// File: rtl/serial_subtractor16.sv
// ============================================================================
// Module : serial_subtractor16
// Brief  : Bit-serial a - b (LSB first, WIDTH cycles) with borrow/overflow/zero.
//          Define SERIAL_SUB_ADD_MODE_EN to add an add_mode port (a + b).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none

module serial_subtractor16
    import alu_serial_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = min_cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef SERIAL_SUB_ADD_MODE_EN
    input  logic             add_mode,
`endif
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             overflow,
    output logic             zero
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

    logic add_in;
`ifdef SERIAL_SUB_ADD_MODE_EN
    assign add_in = add_mode;
`else
    assign add_in = 1'b0;
`endif

    state_e             state_q, state_d;
    logic               in_ready_q, in_ready_d;
    logic               out_valid_q, out_valid_d;
    logic [WIDTH-1:0]   sh_a_q, sh_a_d;
    logic [WIDTH-1:0]   sh_b_q, sh_b_d;
    logic [WIDTH-1:0]   diff_q, diff_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [1:0]         msb_q, msb_d;
    logic               add_q, add_d;
    logic               borrow_q, borrow_d;
    logic               overflow_q, overflow_d;
    logic               zero_q, zero_d;

    logic               cell_load;
    logic               cell_preset;
    logic               cell_en;
    logic               w_s;
    logic               w_cout;

    serial_bit_cell u_cell (
        .clk          (clk),
        .rst_n        (rst_n),
        .load         (cell_load),
        .carry_preset (cell_preset),
        .en           (cell_en),
        .a_bit        (sh_a_q[0]),
        .b_bit        (sh_b_q[0]),
        .s            (w_s),
        .carry_next   (w_cout)
    );

    always_comb begin
        state_d     = state_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        sh_a_d      = sh_a_q;
        sh_b_d      = sh_b_q;
        diff_d      = diff_q;
        count_d     = count_q;
        msb_d       = msb_q;
        add_d       = add_q;
        borrow_d    = borrow_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;
        cell_load   = 1'b0;
        cell_preset = 1'b1;
        cell_en     = 1'b0;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    state_d     = RUN;
                    in_ready_d  = 1'b0;
                    sh_a_d      = a;
                    // Subtract is a + ~b + 1; add leaves b as-is with carry-in 0.
                    sh_b_d      = add_in ? b : ~b;
                    count_d     = '0;
                    msb_d       = {a[WIDTH-1], b[WIDTH-1]};
                    add_d       = add_in;
                    zero_d      = 1'b1;
                    cell_load   = 1'b1;
                    cell_preset = ~add_in;
                end
            end
            RUN: begin
                cell_en = 1'b1;
                diff_d  = {w_s, diff_q[WIDTH-1:1]};
                sh_a_d  = {1'b0, sh_a_q[WIDTH-1:1]};
                sh_b_d  = {1'b0, sh_b_q[WIDTH-1:1]};
                count_d = count_q + CNT_W'(1);
                zero_d  = zero_q & ~w_s;
                if (count_q == LAST_CNT) begin
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    borrow_d    = ~(w_cout ^ add_q);
                    overflow_d  = (msb_q[1] ^ msb_q[0] ^ add_q) & (w_s ^ msb_q[1]);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                end
            end
            default: begin
                state_d     = IDLE;
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            sh_a_q      <= '0;
            sh_b_q      <= '0;
            diff_q      <= '0;
            count_q     <= '0;
            msb_q       <= '0;
            add_q       <= 1'b0;
            borrow_q    <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            sh_a_q      <= sh_a_d;
            sh_b_q      <= sh_b_d;
            diff_q      <= diff_d;
            count_q     <= count_d;
            msb_q       <= msb_d;
            add_q       <= add_d;
            borrow_q    <= borrow_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign borrow    = borrow_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule : serial_subtractor16

`default_nettype wire

// File: tb/tb_serial_subtractor16.sv
// ============================================================================
// Module : tb_serial_subtractor16
// Brief  : Self-checking bench for serial_subtractor16 (arithmetic model plus
//          hand-computed directed vectors).
// Rev    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_serial_subtractor16;

    localparam int WIDTH = 16;

    logic        clk        = 1'b0;
    logic        rst_n      = 1'b0;
    logic        in_valid   = 1'b0;
    logic        out_ready  = 1'b0;
    logic        add_mode_r = 1'b0;
    logic [15:0] a          = '0;
    logic [15:0] b          = '0;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] diff;
    logic        borrow;
    logic        overflow;
    logic        zero;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    serial_subtractor16 #(
        .WIDTH (16),
        .CNT_W (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
`ifdef SERIAL_SUB_ADD_MODE_EN
        .add_mode  (add_mode_r),
`endif
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .overflow  (overflow),
        .zero      (zero)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Plain integer arithmetic: {diff, borrow/carry, signed overflow, zero}.
    function automatic logic [18:0] model_op(input logic [15:0] x, input logic [15:0] y,
                                             input logic add);
        int          sx;
        int          sy;
        int          ux;
        int          uy;
        int          sr;
        int          ur;
        logic [15:0] r;
        logic        fb;
        sx = int'($signed(x));
        sy = int'($signed(y));
        ux = int'(x);
        uy = int'(y);
        if (add) begin
            sr = sx + sy;
            ur = ux + uy;
            fb = (ur > 65535);
        end else begin
            sr = sx - sy;
            ur = ux - uy;
            fb = (ur < 0);
        end
        r = ur[15:0];
        return {r, fb, (sr > 32767) || (sr < -32768), (r == 16'h0000)};
    endfunction

    int          m_state = 0;
    int          m_cnt   = 0;
    logic [18:0] m_pend  = '0;
    logic [18:0] m_res   = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_state <= 0;
            m_cnt   <= 0;
            m_res   <= '0;
        end else begin
            case (m_state)
                0: if (in_valid) begin
                    m_pend  <= model_op(a, b, add_mode_r);
                    m_cnt   <= 0;
                    m_state <= 1;
                end
                1: begin
                    m_cnt <= m_cnt + 1;
                    if (m_cnt == WIDTH - 1) begin
                        m_state <= 2;
                        m_res   <= m_pend;
                    end
                end
                default: if (out_ready) m_state <= 0;
            endcase
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("cmp_out_valid", 32'(out_valid), 32'(m_state == 2));
            check("cmp_in_ready", 32'(in_ready), 32'(m_state == 0));
            if (m_state == 2) begin
                check("cmp_diff", 32'(diff), 32'(m_res[18:3]));
                check("cmp_borrow", 32'(borrow), 32'(m_res[2]));
                check("cmp_overflow", 32'(overflow), 32'(m_res[1]));
                check("cmp_zero", 32'(zero), 32'(m_res[0]));
            end
        end
    end

    task automatic start_op(input logic [15:0] x, input logic [15:0] y, input logic am);
        a          = x;
        b          = y;
        add_mode_r = am;
        in_valid   = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, "_latency"}, 32'(n), 32'(WIDTH));
    endtask

    task automatic expect_result(input string tag, input logic [15:0] ed, input logic eb,
                                 input logic eo, input logic ez);
        check({tag, "_diff"}, 32'(diff), 32'(ed));
        check({tag, "_borrow"}, 32'(borrow), 32'(eb));
        check({tag, "_overflow"}, 32'(overflow), 32'(eo));
        check({tag, "_zero"}, 32'(zero), 32'(ez));
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        check({tag, "_idle_in_ready"}, 32'(in_ready), 32'd1);
        check({tag, "_idle_out_valid"}, 32'(out_valid), 32'd0);
    endtask

    task automatic run_op(input string tag, input logic [15:0] x, input logic [15:0] y,
                          input logic am, input logic [15:0] ed, input logic eb,
                          input logic eo, input logic ez);
        start_op(x, y, am);
        wait_done(tag);
        expect_result(tag, ed, eb, eo, ez);
        handoff(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_flags", 32'({borrow, overflow, zero}), 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        run_op("sub_5_3", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
        run_op("sub_3_5", 16'h0003, 16'h0005, 1'b0, 16'hFFFE, 1'b1, 1'b0, 1'b0);
        run_op("sub_8000_1", 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0);
        run_op("sub_7fff_ffff", 16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

        // Backpressure: result must hold and a new request must be ignored.
        start_op(16'h1234, 16'h1234, 1'b0);
        wait_done("bp");
        expect_result("bp", 16'h0000, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 10; i++) begin
            if (i == 3) begin
                a        = 16'h0F0F;
                b        = 16'h0001;
                in_valid = 1'b1;
            end
            if (i == 6) in_valid = 1'b0;
            @(posedge clk);
            #1;
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_diff", 32'(diff), 32'h0000);
            check("bp_zero", 32'(zero), 32'd1);
        end
        handoff("bp");

        // Asynchronous reset in the middle of a run.
        start_op(16'h00FF, 16'h0001, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_diff", 32'(diff), 32'd0);
        check("midrst_flags", 32'({borrow, overflow, zero}), 32'd0);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        run_op("after_rst", 16'h0010, 16'h0010, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1);

`ifdef SERIAL_SUB_ADD_MODE_EN
        run_op("add_ffff_1", 16'hFFFF, 16'h0001, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
        run_op("add_7fff_1", 16'h7FFF, 16'h0001, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
        run_op("addsel_sub", 16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);
`endif

        run_op("sub_0_8000", 16'h0000, 16'h8000, 1'b0, 16'h8000, 1'b1, 1'b1, 1'b0);

        repeat (2) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_subtractor16

`default_nettype wire
